// File: rtl/lut_arb_pkg.sv
// Shared types and default sizing for the LUT port arbiter and its read-return path.
package lut_arb_pkg;

    localparam int LUT_ADDR_WIDTH = 10;
    localparam int LUT_DATA_WIDTH = 16;
    localparam int LUT_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        ST_SHARE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXCL  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_LK = 1'b0,
        OWN_CF = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/lut_rd_return.sv
// Tracks reads in flight to the LUT RAM and steers each returned word to the
// requester that issued it, two cycles after the grant.
module lut_rd_return
    import lut_arb_pkg::*;
#(
    parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  owner_t                issue_owner,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  read_pending,
    output logic                  lk_valid,
    output logic [DATA_WIDTH-1:0] lk_data,
    output logic                  cf_valid,
    output logic [DATA_WIDTH-1:0] cf_rdata
);

    rd_tag_t               tag_s0;
    rd_tag_t               tag_s1;
    logic [DATA_WIDTH-1:0] lk_data_q;
    logic [DATA_WIDTH-1:0] cf_rdata_q;

    // tag_s0 lines up with the cycle the RAM presents data; tag_s1 with the output cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_s0     <= '0;
            tag_s1     <= '0;
            lk_data_q  <= '0;
            cf_rdata_q <= '0;
        end else begin
            tag_s0 <= '{valid: issue_valid, owner: issue_owner};
            tag_s1 <= tag_s0;
            if (tag_s0.valid && tag_s0.owner == OWN_LK)
                lk_data_q <= ram_rd_data;
            if (tag_s0.valid && tag_s0.owner == OWN_CF)
                cf_rdata_q <= ram_rd_data;
        end
    end

    assign read_pending = tag_s0.valid;
    assign lk_valid     = tag_s1.valid && (tag_s1.owner == OWN_LK);
    assign cf_valid     = tag_s1.valid && (tag_s1.owner == OWN_CF);
    assign lk_data      = lk_data_q;
    assign cf_rdata     = cf_rdata_q;

endmodule

// File: rtl/lut_port_arbiter.sv
// Shares one single-port LUT RAM between the audio lookup path and the config path.
//   state    | meaning
//   ST_SHARE | both requesters served; lookup wins unless config is starved
//   ST_DRAIN | lookups blocked, waiting for outstanding reads to return
//   ST_EXCL  | config owns the table exclusively (reload in progress)
module lut_port_arbiter
    import lut_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = LUT_DATA_WIDTH,
    parameter int STARVE_MAX = LUT_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lk_req,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic                  lk_gnt,
    output logic [DATA_WIDTH-1:0] lk_data,
    output logic                  lk_valid,
    input  logic                  cf_req,
    input  logic                  cf_we,
    input  logic [ADDR_WIDTH-1:0] cf_addr,
    input  logic [DATA_WIDTH-1:0] cf_wdata,
    input  logic                  cf_excl,
    output logic                  cf_gnt,
    output logic [DATA_WIDTH-1:0] cf_rdata,
    output logic                  cf_valid,
    output logic                  cf_excl_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t            state;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  read_pending;
    logic                  issue_valid;
    owner_t                issue_owner;

    always_comb begin
        lk_gnt = 1'b0;
        cf_gnt = 1'b0;
        if (!rst) begin
            case (state)
                ST_SHARE: begin
                    if (cf_req && starve_cnt == STARVE_W'(STARVE_MAX))
                        cf_gnt = 1'b1;
                    else if (lk_req)
                        lk_gnt = 1'b1;
                    else if (cf_req)
                        cf_gnt = 1'b1;
                end
                default: cf_gnt = cf_req;
            endcase
        end
    end

    // Idle cycles keep the previous address on the RAM pins to avoid needless toggling
    assign ram_addr    = lk_gnt ? lk_addr : (cf_gnt ? cf_addr : last_addr_q);
    assign ram_wr_en   = cf_gnt && cf_we;
    assign ram_wr_data = cf_wdata;
    assign cf_excl_ack = (state == ST_EXCL);
    assign issue_valid = lk_gnt || (cf_gnt && !cf_we);
    assign issue_owner = lk_gnt ? OWN_LK : OWN_CF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SHARE;
            starve_cnt  <= '0;
            last_addr_q <= '0;
        end else begin
            last_addr_q <= ram_addr;
            if (cf_gnt)
                starve_cnt <= '0;
            else if (cf_req && starve_cnt != STARVE_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + STARVE_W'(1);

            case (state)
                ST_SHARE: if (cf_excl) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!cf_excl)
                        state <= ST_SHARE;
                    else if (!read_pending)
                        state <= ST_EXCL;
                end
                ST_EXCL:  if (!cf_excl) state <= ST_SHARE;
                default:  state <= ST_SHARE;
            endcase
        end
    end

    lut_rd_return #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_return (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_owner (issue_owner),
        .ram_rd_data (ram_rd_data),
        .read_pending(read_pending),
        .lk_valid    (lk_valid),
        .lk_data     (lk_data),
        .cf_valid    (cf_valid),
        .cf_rdata    (cf_rdata)
    );

endmodule
